mips_wait_mem: RTL and testbench

- Word-addressed data-memory responder for the MIPS core's load/store port.
- Replaces the zero-latency memory model with a req/ack handshake and a parameterised number of wait states.
- Lets the core and the benches exercise stall behaviour and error reporting.
- Sits between the core's data-memory port (ALU result as address, rt value as write data) and a storage array.

---
 rtl/mips_wait_mem_pkg.sv | 6 +
 rtl/mips_wait_mem_if.sv | 14 +
 rtl/mips_wait_mem_array.sv | 21 ++
 rtl/mips_wait_mem.sv | 92 +++++++++
 tb/tb_mips_wait_mem.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_wait_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the wait-state data memory
package mips_mem_pkg;
    localparam int         WORD_W = 32;
    localparam logic [1:0] ALIGN  = 2'b00;
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, WAIT = 2'd2} state_t;
endpackage

// File: rtl/mips_wait_mem_if.sv
// mips_wait_mem_if: req/ack load-store bus between the core and the data memory
interface mips_wait_mem_if;
    import mips_mem_pkg::*;
    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              ack;
    logic [WORD_W-1:0] rdata;
    logic              err;
    logic              busy;
    modport master (output req, we, addr, wdata, input ack, rdata, err, busy);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/mips_wait_mem_array.sv
// mips_mem_array: single-port RAM with synchronous write and synchronous read
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    // write when enabled, always register the old contents at idx
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end
endmodule

// File: rtl/mips_wait_mem.sv
// mips_wait_mem: req/ack data-memory responder with configurable wait states
module mips_wait_mem
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    mips_wait_mem_if.slave bus
);
    localparam int                IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WORD_W-1:0] SPAN  = WORD_W'(DEPTH_WORDS * 4);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              we_q, err_q, sel_ram;
    logic [WORD_W-1:0] addr_q, wdata_q, rdata_q, ram_rdata;
    logic              cur_we, cur_err, enter_resp, ram_we;
    logic [WORD_W-1:0] cur_addr, cur_wdata, off;
    logic [IDX_W-1:0]  idx;

    // in IDLE the bus is the transaction being captured; afterwards only the latched copy counts
    assign cur_we     = (state == IDLE) ? bus.we    : we_q;
    assign cur_addr   = (state == IDLE) ? bus.addr  : addr_q;
    assign cur_wdata  = (state == IDLE) ? bus.wdata : wdata_q;
    assign off        = cur_addr - BASE_ADDR;
    assign cur_err    = (cur_addr[1:0] != ALIGN) || (off >= SPAN);
    assign idx        = off[IDX_W+1:2];
    assign enter_resp = (state_nx == RESP) && (state != RESP);
    assign ram_we     = enter_resp && cur_we && !cur_err && !reset;

    assign bus.ack   = (state == RESP);
    assign bus.busy  = (state != IDLE);
    assign bus.err   = err_q;
    assign bus.rdata = sel_ram ? ram_rdata : rdata_q;

    mips_mem_array #(.DEPTH(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (ram_we),
        .idx   (idx),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    // next state: capture, count down wait states, then one ack cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.req) begin
                state_nx = (LATENCY == 0) ? RESP : WAIT;
                cnt_nx   = 4'(LATENCY);
            end
            WAIT: begin
                state_nx = (cnt == 4'd1) ? RESP : WAIT;
                cnt_nx   = cnt - 4'd1;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, request latch and response registers; load data is taken straight from the RAM during ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            err_q   <= 1'b0;
            sel_ram <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (enter_resp) begin
                err_q   <= cur_err;
                sel_ram <= !cur_err && !cur_we;
                rdata_q <= cur_err ? '0 : (cur_we ? cur_wdata : rdata_q);
            end else if (state == RESP) begin
                err_q   <= 1'b0;
                sel_ram <= 1'b0;
                rdata_q <= bus.rdata;
            end
        end
    end
endmodule

// File: tb/tb_mips_wait_mem.sv
// tb_mips_wait_mem: checks a LATENCY=2 and a LATENCY=0 memory against a transaction-level model
module tb_mips_wait_mem;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        req_s [2];
    logic        we_s [2];
    logic [31:0] addr_s [2];
    logic [31:0] wdata_s [2];
    logic        ack_s [2];
    logic        busy_s [2];
    logic        err_s [2];
    logic [31:0] rdata_s [2];

    logic        m_busy [2];
    logic        m_ack [2];
    logic        m_err [2];
    logic        m_rk [2];
    logic [31:0] m_rdata [2];
    int          m_rem [2];
    logic        m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] mem_m [int];

    always #5 clk = ~clk;

    mips_wait_mem_if bus_a ();
    mips_wait_mem_if bus_b ();

    mips_wait_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    mips_wait_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    assign bus_a.req   = req_s[0];
    assign bus_a.we    = we_s[0];
    assign bus_a.addr  = addr_s[0];
    assign bus_a.wdata = wdata_s[0];
    assign bus_b.req   = req_s[1];
    assign bus_b.we    = we_s[1];
    assign bus_b.addr  = addr_s[1];
    assign bus_b.wdata = wdata_s[1];
    assign ack_s[0]    = bus_a.ack;
    assign busy_s[0]   = bus_a.busy;
    assign err_s[0]    = bus_a.err;
    assign rdata_s[0]  = bus_a.rdata;
    assign ack_s[1]    = bus_b.ack;
    assign busy_s[1]   = bus_b.busy;
    assign err_s[1]    = bus_b.err;
    assign rdata_s[1]  = bus_b.rdata;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic void chk(input string n, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h at cycle %0d", n, d, act, exp, cyc);
        end
    endfunction

    // transaction model: a capture starts a countdown of LATENCY edges, after which the access is applied
    initial forever begin
        logic [31:0] off;
        int          key;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_busy[d] = 1'b0; m_ack[d] = 1'b0; m_err[d] = 1'b0;
                m_rdata[d] = '0;  m_rk[d] = 1'b1;
            end else if (m_ack[d]) begin
                m_busy[d] = 1'b0; m_ack[d] = 1'b0; m_err[d] = 1'b0;
            end else begin
                if (!m_busy[d] && req_s[d]) begin
                    m_busy[d] = 1'b1; m_rem[d] = lat_of(d);
                    m_we[d] = we_s[d]; m_addr[d] = addr_s[d]; m_wdata[d] = wdata_s[d];
                end else if (m_busy[d]) m_rem[d]--;
                if (m_busy[d] && m_rem[d] == 0) begin
                    m_ack[d] = 1'b1;
                    off = m_addr[d] - BASE;
                    m_err[d] = (m_addr[d][1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
                    key = d * DEPTH + int'(off >> 2);
                    if (m_err[d]) begin
                        m_rdata[d] = '0; m_rk[d] = 1'b1;
                    end else if (m_we[d]) begin
                        mem_m[key] = m_wdata[d]; m_rdata[d] = m_wdata[d]; m_rk[d] = 1'b1;
                    end else begin
                        m_rk[d] = mem_m.exists(key);
                        m_rdata[d] = m_rk[d] ? mem_m[key] : '0;
                    end
                end
            end
        end
    end

    // every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (run) begin
            for (int d = 0; d < 2; d++) begin
                chk("ack", d, 32'(ack_s[d]), 32'(m_ack[d]));
                chk("busy", d, 32'(busy_s[d]), 32'(m_busy[d]));
                chk("err", d, 32'(err_s[d]), 32'(m_err[d]));
                if (m_rk[d]) chk("rdata", d, rdata_s[d], m_rdata[d]);
            end
        end
    end

    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_e);
        int k;
        req_s[d] = 1'b1; we_s[d] = w; addr_s[d] = a; wdata_s[d] = wd;
        @(posedge clk); #1;
        addr_s[d] = ~a; wdata_s[d] = 32'hCAFE_F00D;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ack_s[d] && k < 20);
        chk("xact_lat", d, 32'(k), 32'(lat_of(d) + 1));
        chk("xact_rdata", d, rdata_s[d], exp_rd);
        chk("xact_err", d, 32'(err_s[d]), 32'(exp_e));
        @(posedge clk); #1;
        req_s[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t [3];
        int k;
        for (int d = 0; d < 2; d++) begin
            req_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
        end
        @(posedge clk); #1;
        run = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_ack", 0, 32'(ack_s[0]), 0);
        chk("idle_busy", 0, 32'(busy_s[0]), 0);
        chk("idle_rdata", 0, rdata_s[0], 0);

        xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        xact(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        xact(0, 1'b1, 32'h13, 32'h7777_7777, 32'h0, 1'b1);
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        xact(0, 1'b1, 32'h0, 32'hA5A5_0000, 32'hA5A5_0000, 1'b0);
        xact(0, 1'b1, 32'h1000, 32'h0000_0BAD, 32'h0, 1'b1);
        xact(0, 1'b1, 32'hFFC, 32'h1234, 32'h1234, 1'b0);
        xact(0, 1'b0, 32'hFFC, 32'h0, 32'h1234, 1'b0);
        xact(0, 1'b0, 32'h0, 32'h0, 32'hA5A5_0000, 1'b0);
        xact(0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1);

        xact(1, 1'b1, 32'h40, 32'h1111_0000, 32'h1111_0000, 1'b0);
        xact(1, 1'b1, 32'h44, 32'h1111_0001, 32'h1111_0001, 1'b0);
        xact(1, 1'b1, 32'h48, 32'h1111_0002, 32'h1111_0002, 1'b0);
        req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h40;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!ack_s[1] && k < 10);
            chk("b2b_ack", 1, 32'(ack_s[1]), 1);
            chk("b2b_rdata", 1, rdata_s[1], 32'(32'h1111_0000 + i));
            t[i] = cyc;
            if (i > 0) chk("b2b_gap", 1, 32'(t[i] - t[i-1]), 2);
            @(posedge clk); #1;
            if (i < 2) addr_s[1] = 32'(32'h40 + 4 * (i + 1));
            else req_s[1] = 1'b0;
            @(negedge clk);
            chk("b2b_idle", 1, 32'(busy_s[1]), 0);
        end

        xact(0, 1'b1, 32'h20, 32'h11, 32'h11, 1'b0);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h55;
        @(posedge clk); #1;
        reset = 1'b1;
        req_s[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("rst_noack", 0, 32'(ack_s[0]), 0);
        end
        xact(0, 1'b0, 32'h20, 32'h0, 32'h11, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
